t05_hist_reader: RTL and testbench
==================================

# t05_hist_reader

- Reads a completed 256-bin byte histogram out of the histogram store, one bin at a time.
- Skips empty bins and hands each (symbol, count) pair downstream, in ascending symbol order, over a valid/ready handshake.
- Sits between histogram accumulation and Huffman tree construction in the compression datapath.
- Reports the number of distinct symbols found when the scan completes.

## Interface
Parameters:
- CNT_W, 32, width of each histogram count

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous abort; returns block to IDLE
- start  in  1  begin scan; sampled only in IDLE
- hist_rd  out  1  read strobe to histogram store
- hist_addr  out  8  bin index being read
- hist_rdata  in  CNT_W  bin count; valid the cycle after hist_rd/hist_addr
- out_valid  out  1  sym/cnt valid
- out_ready  in  1  downstream accepts
- out_sym  out  8  symbol (bin index)
- out_cnt  out  CNT_W  nonzero count for out_sym
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse at scan end
- nsym  out  9  nonzero bins emitted this scan (0..256); held until next start
- exp_total  in  32  expected byte total (used only with checksum)
- sum  out  32  sum of emitted counts
- sum_err  out  1  checksum mismatch flag

## Operation
- States: IDLE, REQ, CAPT, EMIT, DONE.
- IDLE:
  - start=1 → idx←0, nsym←0, sum←0, sum_err←0; go to REQ.
  - start while not IDLE is ignored.
- REQ:
  - hist_rd=1, hist_addr=idx; go to CAPT.
- CAPT: hist_rdata is valid.
  - If zero: idx==255 → DONE; else idx←idx+1 → REQ.
  - If nonzero: latch out_sym←idx, out_cnt←hist_rdata; go to EMIT.
- EMIT:
  - out_valid=1; out_sym and out_cnt are held stable until the handshake.
  - On out_valid&&out_ready: nsym←nsym+1, sum←sum+out_cnt (wraps mod 2^32); idx==255 → DONE, else idx←idx+1 → REQ.
- DONE:
  - done=1 for this cycle only; go to IDLE.
- clear=1 in any state → IDLE next edge; out_valid drops; nsym/sum keep current values. clear beats start when both are asserted.
- hist_addr holds its last value when hist_rd=0.
- nsym=256 is reachable (all bins nonzero); it is 9 bits so it does not wrap.

## Timing
- Reset values: state IDLE; hist_rd, out_valid, busy, done, sum_err = 0; hist_addr, out_sym, out_cnt, nsym, sum = 0.
- Per bin: zero bin = 2 cycles (REQ, CAPT); nonzero bin = 3 cycles + out_ready stall cycles.
- Empty histogram: done is high in the cycle starting 513 edges after the start-sampling edge (1 IDLE→REQ + 512 bin cycles).
- out_valid asserts the cycle after CAPT sees nonzero data. It never deasserts without a handshake, except on clear or rst.
- out_ready while out_valid=0 is ignored.
- rst mid-scan: asynchronous return to IDLE with all reset values; no done pulse.

## Configuration
- Macro: T05_HIST_READER_SUM_EN.
- Defined:
  - sum accumulates as described.
  - In DONE, sum_err←(sum + count accepted this cycle, if any) != exp_total; held until the next start.
- Undefined:
  - sum and sum_err are tied to 0.
  - exp_total is unused.
  - No adder is synthesized.

## Test plan
- All bins zero, start pulse → no out_valid; done pulses 513 cycles after start; nsym=0.
- Bins 0x41=3, 0x1A=1, 0xFF=7, out_ready tied 1 → outputs (0x1A,1), (0x41,3), (0xFF,7) in order; nsym=3; with macro and exp_total=11 → sum=11, sum_err=0.
- Same histogram, exp_total=12, macro defined → sum_err=1 after done.
- Bin 0x05=9, out_ready held low 10 cycles → out_valid stays 1 with out_sym=0x05, out_cnt=9 unchanged; accepted the cycle out_ready rises.
- All 256 bins =1 → 256 pairs emitted, symbols 0x00..0xFF in order; nsym=256.
- clear asserted during EMIT of the 2nd pair → IDLE next cycle, no done; a new start rescans from bin 0.

Source files
------------

// File: rtl/t05_hist_reader.sv
// rtl/t05_hist_reader.sv - scans a 256-bin histogram store and streams nonzero (symbol, count) pairs
// Optional running checksum of emitted counts enabled by defining T05_HIST_READER_SUM_EN.
`timescale 1ns/1ps
module t05_hist_reader #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             start_i,
   output logic             hist_rd_o,
   output logic [7:0]       hist_addr_o,
   input  logic [CNT_W-1:0] hist_rdata_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [7:0]       out_sym_o,
   output logic [CNT_W-1:0] out_cnt_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [8:0]       nsym_o,
   input  logic [31:0]      exp_total_i,
   output logic [31:0]      sum_o,
   output logic             sum_err_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_CAPT,
      S_EMIT,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       idx_q, idx_d;
   logic [7:0]       sym_q, sym_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [8:0]       nsym_q, nsym_d;
   logic             scan_start;
   logic             accept;
   logic             in_done;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      sym_d      = sym_q;
      cnt_d      = cnt_q;
      nsym_d     = nsym_q;
      scan_start = 1'b0;
      accept     = 1'b0;
      in_done    = 1'b0;
      // clear freezes every datapath register and only redirects the FSM
      if (clear_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  scan_start = 1'b1;
                  idx_d      = 8'd0;
                  nsym_d     = 9'd0;
                  state_d    = S_REQ;
               end
            end
            S_REQ: begin
               state_d = S_CAPT;
            end
            S_CAPT: begin
               if (hist_rdata_i == '0) begin
                  if (idx_q == 8'hFF) begin
                     state_d = S_DONE;
                  end else begin
                     idx_d   = idx_q + 8'd1;
                     state_d = S_REQ;
                  end
               end else begin
                  sym_d   = idx_q;
                  cnt_d   = hist_rdata_i;
                  state_d = S_EMIT;
               end
            end
            S_EMIT: begin
               if (out_ready_i) begin
                  accept = 1'b1;
                  nsym_d = nsym_q + 9'd1;
                  if (idx_q == 8'hFF) begin
                     state_d = S_DONE;
                  end else begin
                     idx_d   = idx_q + 8'd1;
                     state_d = S_REQ;
                  end
               end
            end
            S_DONE: begin
               in_done = 1'b1;
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q  <= 8'd0;
         sym_q  <= 8'd0;
         cnt_q  <= '0;
         nsym_q <= 9'd0;
      end else begin
         idx_q  <= idx_d;
         sym_q  <= sym_d;
         cnt_q  <= cnt_d;
         nsym_q <= nsym_d;
      end
   end

   // idx only moves on the edge into REQ, so it doubles as the held read address
   assign hist_rd_o   = (state_q == S_REQ);
   assign hist_addr_o = idx_q;
   assign out_valid_o = (state_q == S_EMIT);
   assign out_sym_o   = sym_q;
   assign out_cnt_o   = cnt_q;
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);
   assign nsym_o      = nsym_q;

`ifdef T05_HIST_READER_SUM_EN
   logic [31:0] sum_q, sum_d;
   logic        sum_err_q, sum_err_d;

   always_comb begin
      sum_d     = sum_q;
      sum_err_d = sum_err_q;
      if (scan_start) begin
         sum_d     = 32'd0;
         sum_err_d = 1'b0;
      end else if (accept) begin
         sum_d = sum_q + 32'(cnt_q);
      end else if (in_done) begin
         sum_err_d = (sum_q != exp_total_i);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sum_q     <= 32'd0;
         sum_err_q <= 1'b0;
      end else begin
         sum_q     <= sum_d;
         sum_err_q <= sum_err_d;
      end
   end

   assign sum_o     = sum_q;
   assign sum_err_o = sum_err_q;
`else
   logic unused_sum_inputs;

   assign unused_sum_inputs = ^{exp_total_i, scan_start, accept, in_done};
   assign sum_o             = 32'd0;
   assign sum_err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_t05_hist_reader.sv
// tb/tb_t05_hist_reader.sv - directed self-checking bench for t05_hist_reader
`timescale 1ns/1ps
module tb_t05_hist_reader;

`ifdef T05_HIST_READER_SUM_EN
   localparam bit SUM_EN = 1'b1;
`else
   localparam bit SUM_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        start = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] exp_total = 32'd0;
   logic        hist_rd;
   logic [7:0]  hist_addr;
   logic [31:0] hist_rdata = 32'd0;
   logic        out_valid;
   logic [7:0]  out_sym;
   logic [31:0] out_cnt;
   logic        busy;
   logic        done;
   logic [8:0]  nsym;
   logic [31:0] sum;
   logic        sum_err;

   logic [31:0] mem [256];
   logic [7:0]  q_sym [$];
   logic [31:0] q_cnt [$];
   int          checks = 0;
   int          failures = 0;
   int          done_cnt = 0;
   int          valid_cycles = 0;

   t05_hist_reader #(.CNT_W(32)) dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
      .hist_rd_o(hist_rd), .hist_addr_o(hist_addr), .hist_rdata_i(hist_rdata),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_sym_o(out_sym), .out_cnt_o(out_cnt),
      .busy_o(busy), .done_o(done), .nsym_o(nsym),
      .exp_total_i(exp_total), .sum_o(sum), .sum_err_o(sum_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (hist_rd) hist_rdata <= mem[hist_addr];
   end

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (out_valid === 1'b1) valid_cycles++;
      if (out_valid === 1'b1 && out_ready === 1'b1 && clear === 1'b0 && rst === 1'b0) begin
         q_sym.push_back(out_sym);
         q_cnt.push_back(out_cnt);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
   endtask

   task automatic run_scan(output int lat);
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 3000) begin
         tick();
         lat++;
      end
      if (done !== 1'b1) begin
         checks++; failures++;
         $display("FAIL scan_timeout: done not seen after %0d cycles", lat);
      end
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (out_valid !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      if (out_valid !== 1'b1) begin
         checks++; failures++;
         $display("FAIL %s: out_valid never asserted", name);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      checks++; if ({hist_rd, out_valid, busy, done, sum_err} !== 5'b0) begin failures++;
         $display("FAIL reset_flags: got %b expected 00000", {hist_rd, out_valid, busy, done, sum_err}); end
      checks++; if (hist_addr !== 8'd0 || out_sym !== 8'd0) begin failures++;
         $display("FAIL reset_addr_sym: got %h/%h expected 00/00", hist_addr, out_sym); end
      checks++; if (out_cnt !== 32'd0 || nsym !== 9'd0 || sum !== 32'd0) begin failures++;
         $display("FAIL reset_counts: got cnt=%0d nsym=%0d sum=%0d expected 0/0/0", out_cnt, nsym, sum); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_empty;
      int lat;
      int v0;
      clear_mem();
      out_ready = 1'b1;
      exp_total = 32'd0;
      q_sym.delete(); q_cnt.delete();
      v0 = valid_cycles;
      run_scan(lat);
      checks++; if (lat !== 513) begin failures++;
         $display("FAIL empty_latency: got %0d expected 513", lat); end
      checks++; if (valid_cycles !== v0 || q_sym.size() !== 0) begin failures++;
         $display("FAIL empty_no_valid: got %0d valid cycles expected 0", valid_cycles - v0); end
      checks++; if (nsym !== 9'd0) begin failures++;
         $display("FAIL empty_nsym: got %0d expected 0", nsym); end
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++;
         $display("FAIL empty_done_pulse: got done=%b busy=%b expected 0/0", done, busy); end
   endtask

   task automatic test_three;
      int lat;
      logic [7:0]  es [3];
      logic [31:0] ec [3];
      es[0] = 8'h1A; es[1] = 8'h41; es[2] = 8'hFF;
      ec[0] = 32'd1; ec[1] = 32'd3; ec[2] = 32'd7;
      clear_mem();
      mem[8'h41] = 32'd3; mem[8'h1A] = 32'd1; mem[8'hFF] = 32'd7;
      out_ready = 1'b1;
      exp_total = 32'd11;
      q_sym.delete(); q_cnt.delete();
      run_scan(lat);
      checks++; if (lat !== 516) begin failures++;
         $display("FAIL three_latency: got %0d expected 516", lat); end
      checks++; if (q_sym.size() !== 3) begin failures++;
         $display("FAIL three_count: got %0d pairs expected 3", q_sym.size()); end
      for (int i = 0; i < 3 && i < q_sym.size(); i++) begin
         checks++; if (q_sym[i] !== es[i] || q_cnt[i] !== ec[i]) begin failures++;
            $display("FAIL three_pair%0d: got (%h,%0d) expected (%h,%0d)", i, q_sym[i], q_cnt[i], es[i], ec[i]); end
      end
      tick();
      checks++; if (nsym !== 9'd3) begin failures++;
         $display("FAIL three_nsym: got %0d expected 3", nsym); end
      checks++; if (sum !== (SUM_EN ? 32'd11 : 32'd0)) begin failures++;
         $display("FAIL three_sum: got %0d expected %0d", sum, SUM_EN ? 11 : 0); end
      checks++; if (sum_err !== 1'b0) begin failures++;
         $display("FAIL three_sum_err: got %b expected 0", sum_err); end
   endtask

   task automatic test_sum_err;
      int lat;
      exp_total = 32'd12;
      q_sym.delete(); q_cnt.delete();
      run_scan(lat);
      tick();
      checks++; if (sum_err !== SUM_EN) begin failures++;
         $display("FAIL sum_err_set: got %b expected %b", sum_err, SUM_EN); end
      checks++; if (nsym !== 9'd3) begin failures++;
         $display("FAIL sum_err_nsym_restart: got %0d expected 3", nsym); end
      tick(); tick();
      checks++; if (sum_err !== SUM_EN) begin failures++;
         $display("FAIL sum_err_held: got %b expected %b", sum_err, SUM_EN); end
   endtask

   task automatic test_stall;
      int n;
      clear_mem();
      mem[8'h05] = 32'd9;
      exp_total = 32'd9;
      out_ready = 1'b0;
      q_sym.delete(); q_cnt.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (sum_err !== 1'b0) begin failures++;
         $display("FAIL stall_err_cleared: got %b expected 0", sum_err); end
      checks++; if (hist_rd !== 1'b1 || hist_addr !== 8'd0) begin failures++;
         $display("FAIL stall_first_req: got rd=%b addr=%h expected 1/00", hist_rd, hist_addr); end
      wait_valid("stall_wait_valid");
      for (int i = 0; i < 10; i++) begin
         checks++; if ({out_valid, out_sym, out_cnt} !== {1'b1, 8'h05, 32'd9}) begin failures++;
            $display("FAIL stall_hold%0d: got v=%b sym=%h cnt=%0d expected 1/05/9", i, out_valid, out_sym, out_cnt); end
         tick();
      end
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0 || nsym !== 9'd1 || q_sym.size() !== 1) begin failures++;
         $display("FAIL stall_accept: got v=%b nsym=%0d pairs=%0d expected 0/1/1", out_valid, nsym, q_sym.size()); end
      n = 0;
      while (done !== 1'b1 && n < 2000) begin tick(); n++; end
      checks++; if (done !== 1'b1) begin failures++;
         $display("FAIL stall_done: done not seen expected pulse"); end
      tick();
   endtask

   task automatic test_all_ones;
      int lat;
      int errs = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'd1;
      out_ready = 1'b1;
      exp_total = 32'd256;
      q_sym.delete(); q_cnt.delete();
      run_scan(lat);
      checks++; if (lat !== 769) begin failures++;
         $display("FAIL ones_latency: got %0d expected 769", lat); end
      checks++; if (q_sym.size() !== 256) begin failures++;
         $display("FAIL ones_count: got %0d pairs expected 256", q_sym.size()); end
      for (int i = 0; i < 256 && i < q_sym.size(); i++) begin
         if (q_sym[i] !== 8'(i) || q_cnt[i] !== 32'd1) errs++;
      end
      checks++; if (errs !== 0) begin failures++;
         $display("FAIL ones_order: got %0d misordered pairs expected 0", errs); end
      tick();
      checks++; if (nsym !== 9'd256) begin failures++;
         $display("FAIL ones_nsym: got %0d expected 256", nsym); end
      checks++; if (sum !== (SUM_EN ? 32'd256 : 32'd0) || sum_err !== 1'b0) begin failures++;
         $display("FAIL ones_sum: got sum=%0d err=%b expected %0d/0", sum, sum_err, SUM_EN ? 256 : 0); end
   endtask

   task automatic test_clear;
      int dc;
      int n;
      clear_mem();
      mem[8'h10] = 32'd2; mem[8'h20] = 32'd4; mem[8'h30] = 32'd6;
      out_ready = 1'b0;
      q_sym.delete(); q_cnt.delete();
      dc = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid("clear_wait_first");
      checks++; if (out_sym !== 8'h10) begin failures++;
         $display("FAIL clear_first_sym: got %h expected 10", out_sym); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      wait_valid("clear_wait_second");
      checks++; if (out_sym !== 8'h20 || out_cnt !== 32'd4) begin failures++;
         $display("FAIL clear_second_pair: got (%h,%0d) expected (20,4)", out_sym, out_cnt); end
      clear = 1'b1;
      tick();
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || nsym !== 9'd1) begin failures++;
         $display("FAIL clear_idle: got busy=%b v=%b nsym=%0d expected 0/0/1", busy, out_valid, nsym); end
      start = 1'b1;
      tick();
      checks++; if (busy !== 1'b0) begin failures++;
         $display("FAIL clear_beats_start: got busy=%b expected 0", busy); end
      clear = 1'b0;
      start = 1'b0;
      tick(); tick(); tick();
      checks++; if (done_cnt !== dc || q_sym.size() !== 1) begin failures++;
         $display("FAIL clear_no_done: got %0d done pulses %0d pairs expected 0/1", done_cnt - dc, q_sym.size()); end
      out_ready = 1'b1;
      q_sym.delete(); q_cnt.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (hist_rd !== 1'b1 || hist_addr !== 8'd0) begin failures++;
         $display("FAIL clear_rescan_bin0: got rd=%b addr=%h expected 1/00", hist_rd, hist_addr); end
      n = 0;
      while (done !== 1'b1 && n < 2000) begin tick(); n++; end
      tick();
      checks++; if (q_sym.size() !== 3 || nsym !== 9'd3 || done_cnt !== dc + 1) begin failures++;
         $display("FAIL clear_rescan: got pairs=%0d nsym=%0d dones=%0d expected 3/3/1", q_sym.size(), nsym, done_cnt - dc); end
      if (q_sym.size() > 0) begin
         checks++; if (q_sym[0] !== 8'h10) begin failures++;
            $display("FAIL clear_rescan_first: got %h expected 10", q_sym[0]); end
      end
   endtask

   task automatic test_rst_midscan;
      int dc;
      for (int i = 0; i < 256; i++) mem[i] = 32'd1;
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || nsym !== 9'd0 || hist_addr !== 8'd0 || out_cnt !== 32'd0) begin failures++;
         $display("FAIL rst_async: got busy=%b v=%b nsym=%0d addr=%h cnt=%0d expected all 0", busy, out_valid, nsym, hist_addr, out_cnt); end
      dc = done_cnt;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      checks++; if (done_cnt !== dc || busy !== 1'b0) begin failures++;
         $display("FAIL rst_no_done: got dones=%0d busy=%b expected 0/0", done_cnt - dc, busy); end
   endtask

   initial begin
      clear_mem();
      test_reset();
      test_empty();
      test_three();
      test_sum_err();
      test_stall();
      test_all_ones();
      test_clear();
      test_rst_midscan();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
